// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer sequencer.
package nn_pkg;

  localparam logic [31:0] FP_ONE = 32'h3F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/neuron_addr_gen.sv
// Beat/neuron counters and x/weight/bias read-address generation for one layer pass.
module neuron_addr_gen #(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int XA_W  = 10,
  parameter int WA_W  = 13,
  parameter int OA_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            step,
  input  logic            next_neuron,
  output logic [XA_W-1:0] x_addr,
  output logic [WA_W-1:0] w_addr,
  output logic [OA_W-1:0] b_addr,
  output logic            last_beat,
  output logic            last_neuron
);

  localparam int I_W = $clog2(N_IN + 1);

  logic [I_W-1:0]  i_q, i_d;
  logic [WA_W-1:0] w_q, w_d;
  logic [OA_W-1:0] n_q, n_d;

  assign last_beat   = (i_q == I_W'(N_IN));
  assign last_neuron = (n_q == OA_W'(N_OUT - 1));

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it unassigned (no latch).
    i_d = i_q;
    w_d = w_q;
    n_d = n_q;
    if (clear) begin
      i_d = '0;
      w_d = '0;
      n_d = '0;
    end else begin
      // The weight pointer only advances on data beats, so it lands on the next row start.
      if (step) begin
        if (last_beat) begin
          i_d = '0;
        end else begin
          i_d = i_q + 1'b1;
          w_d = w_q + 1'b1;
        end
      end
      if (next_neuron) n_d = n_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so all registers update together at the edge.
    if (rst) begin
      i_q <= '0;
      w_q <= '0;
      n_q <= '0;
    end else begin
      i_q <= i_d;
      w_q <= w_d;
      n_q <= n_d;
    end
  end

  assign x_addr = XA_W'(i_q);
  assign w_addr = w_q;
  assign b_addr = n_q;

endmodule

// File: rtl/neuron_seq_ctrl.sv
// Drives one float32 MAC junction through a fully-connected layer, one neuron at a time.
module neuron_seq_ctrl
  import nn_pkg::*;
#(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int XA_W  = 10,
  parameter int WA_W  = 13,
  parameter int OA_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [XA_W-1:0] x_addr,
  input  logic [31:0]     x_rdata,
  output logic [WA_W-1:0] w_addr,
  input  logic [31:0]     w_rdata,
  output logic [OA_W-1:0] b_addr,
  input  logic [31:0]     b_rdata,
  output logic [31:0]     j_x,
  output logic [31:0]     j_weight,
  output logic            j_x_valid,
  output logic            j_w_valid,
  output logic            j_x_last,
  input  logic [31:0]     j_result,
  input  logic            j_result_valid,
  output logic            o_we,
  output logic [OA_W-1:0] o_addr,
  output logic [31:0]     o_data
);

  state_e      state_q, state_d;
  logic        beat_valid_q, beat_valid_d;
  logic        beat_last_q, beat_last_d;
  logic [31:0] o_data_q, o_data_d;
  logic        last_beat, last_neuron;

  neuron_addr_gen #(
    .N_IN (N_IN),
    .N_OUT(N_OUT),
    .XA_W (XA_W),
    .WA_W (WA_W),
    .OA_W (OA_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q == ST_IDLE),
    .step       (state_q == ST_STREAM),
    .next_neuron(state_q == ST_WRITE && !last_neuron),
    .x_addr     (x_addr),
    .w_addr     (w_addr),
    .b_addr     (b_addr),
    .last_beat  (last_beat),
    .last_neuron(last_neuron)
  );

  always_comb begin
    state_d      = state_q;
    o_data_d     = o_data_q;
    beat_valid_d = (state_q == ST_STREAM);
    beat_last_d  = (state_q == ST_STREAM) && last_beat;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_STREAM;
      ST_STREAM: if (last_beat) state_d = ST_WAIT;
      ST_WAIT: begin
        if (j_result_valid) begin
          o_data_d = j_result;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE:  state_d = last_neuron ? ST_DONE : ST_STREAM;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_valid_q <= 1'b0;
      beat_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_valid_q <= beat_valid_d;
      beat_last_q  <= beat_last_d;
    end
  end

  // NOTE: o_data is a pure datapath register qualified by o_we, so it carries no reset.
  always_ff @(posedge clk) begin
    o_data_q <= o_data_d;
  end

  // Strobes are masked by rst so an in-progress layer emits nothing in the reset cycle.
  assign busy      = (state_q == ST_STREAM) || (state_q == ST_WAIT) || (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE) && !rst;
  assign o_we      = (state_q == ST_WRITE) && !rst;
  assign o_addr    = b_addr;
  assign o_data    = o_data_q;
  assign j_x_valid = beat_valid_q && !rst;
  assign j_w_valid = j_x_valid;
  assign j_x_last  = beat_last_q && !rst;
  assign j_x       = beat_last_q ? FP_ONE : x_rdata;
  assign j_weight  = beat_last_q ? b_rdata : w_rdata;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Directed bench: two layer configurations, sync-read memories and a 12-cycle float MAC junction model.
module tb_neuron_seq_ctrl;
  import nn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, spur_valid;
  logic [31:0] spur_data;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: N_IN=4, N_OUT=2
  logic        busy_a, done_a, j_x_valid_a, j_w_valid_a, j_x_last_a, o_we_a, j_result_valid_a;
  logic [2:0]  x_addr_a, w_addr_a;
  logic [0:0]  b_addr_a, o_addr_a;
  logic [31:0] x_rdata_a, w_rdata_a, b_rdata_a, j_x_a, j_weight_a, j_result_a, o_data_a;
  logic [31:0] x_mem_a[8], w_mem_a[8], b_mem_a[2];

  neuron_seq_ctrl #(.N_IN(4), .N_OUT(2), .XA_W(3), .WA_W(3), .OA_W(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .x_addr(x_addr_a), .x_rdata(x_rdata_a), .w_addr(w_addr_a), .w_rdata(w_rdata_a),
    .b_addr(b_addr_a), .b_rdata(b_rdata_a), .j_x(j_x_a), .j_weight(j_weight_a),
    .j_x_valid(j_x_valid_a), .j_w_valid(j_w_valid_a), .j_x_last(j_x_last_a),
    .j_result(j_result_a), .j_result_valid(j_result_valid_a),
    .o_we(o_we_a), .o_addr(o_addr_a), .o_data(o_data_a)
  );

  // Instance B: N_IN=1, N_OUT=1
  logic        busy_b, done_b, j_x_valid_b, j_w_valid_b, j_x_last_b, o_we_b, j_result_valid_b;
  logic [0:0]  x_addr_b, w_addr_b, b_addr_b, o_addr_b;
  logic [31:0] x_rdata_b, w_rdata_b, b_rdata_b, j_x_b, j_weight_b, j_result_b, o_data_b;
  logic [31:0] x_mem_b[2], w_mem_b[2], b_mem_b[2];

  neuron_seq_ctrl #(.N_IN(1), .N_OUT(1), .XA_W(1), .WA_W(1), .OA_W(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .x_addr(x_addr_b), .x_rdata(x_rdata_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
    .b_addr(b_addr_b), .b_rdata(b_rdata_b), .j_x(j_x_b), .j_weight(j_weight_b),
    .j_x_valid(j_x_valid_b), .j_w_valid(j_w_valid_b), .j_x_last(j_x_last_b),
    .j_result(j_result_b), .j_result_valid(j_result_valid_b),
    .o_we(o_we_b), .o_addr(o_addr_b), .o_data(o_data_b)
  );

  // Sync-read memories, one cycle latency
  always @(posedge clk) begin
    x_rdata_a <= x_mem_a[x_addr_a];
    w_rdata_a <= w_mem_a[w_addr_a];
    b_rdata_a <= b_mem_a[b_addr_a];
    x_rdata_b <= x_mem_b[x_addr_b];
    w_rdata_b <= w_mem_b[w_addr_b];
    b_rdata_b <= b_mem_b[b_addr_b];
  end

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Junction models: accumulate, emit result 12 cycles after the last beat
  real         acc_a = 0.0, acc_b = 0.0;
  int          cnt_a = 0, cnt_b = 0;
  logic        mv_a = 1'b0, mv_b = 1'b0;
  logic [31:0] res_a = '0, res_b = '0;

  always @(posedge clk) begin
    mv_a <= (cnt_a == 1);
    if (cnt_a > 0) cnt_a <= cnt_a - 1;
    if (j_x_valid_a) begin
      acc_a = acc_a + f2r(j_x_a) * f2r(j_weight_a);
      if (j_x_last_a) begin
        res_a <= r2f(acc_a);
        acc_a = 0.0;
        cnt_a <= 12;
      end
    end
    mv_b <= (cnt_b == 1);
    if (cnt_b > 0) cnt_b <= cnt_b - 1;
    if (j_x_valid_b) begin
      acc_b = acc_b + f2r(j_x_b) * f2r(j_weight_b);
      if (j_x_last_b) begin
        res_b <= r2f(acc_b);
        acc_b = 0.0;
        cnt_b <= 12;
      end
    end
  end

  assign j_result_valid_a = mv_a | spur_valid;
  assign j_result_a       = mv_a ? res_a : spur_data;
  assign j_result_valid_b = mv_b;
  assign j_result_b       = res_b;

  // Output monitor, sampled mid-cycle
  int          run_a = 0, runs_ok_a = 0, runs_bad_a = 0, last_ok_a = 0, last_bad_a = 0, sig_bad_a = 0;
  int          we_cnt_a = 0, done_cnt_a = 0, we_cyc_a = 0, done_cyc_a = 0;
  logic [31:0] we_data_a[8];
  logic [31:0] we_addr_a[8];
  int          we_cnt_b = 0, done_cnt_b = 0, we_cyc_b = 0, done_cyc_b = 0;
  logic [31:0] we_data_b = '0, we_addr_b = '0;

  always @(negedge clk) begin
    if (j_x_valid_a) begin
      run_a++;
      if (j_x_last_a) begin
        if (run_a == 5 && j_x_a == FP_ONE) last_ok_a++;
        else last_bad_a++;
      end
    end else if (run_a != 0) begin
      if (run_a == 5) runs_ok_a++;
      else runs_bad_a++;
      run_a = 0;
    end
    if ((j_x_last_a && !j_x_valid_a) || (j_w_valid_a !== j_x_valid_a)) sig_bad_a++;
    if (o_we_a) begin
      if (we_cnt_a < 8) begin
        we_data_a[we_cnt_a] = o_data_a;
        we_addr_a[we_cnt_a] = 32'(o_addr_a);
      end
      we_cnt_a++;
      we_cyc_a = cyc;
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (o_we_b) begin
      we_cnt_b++;
      we_data_b = o_data_b;
      we_addr_b = 32'(o_addr_b);
      we_cyc_b  = cyc;
    end
    if (done_b) begin
      done_cnt_b++;
      done_cyc_b = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done_a(input int budget);
    int base;
    base = done_cnt_a;
    for (int k = 0; k < budget && done_cnt_a == base; k++) step(1);
    check("done_a_within_budget", 32'(done_cnt_a - base), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    spur_valid = 1'b0; spur_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 8; k++) begin
      x_mem_a[k]   = 32'd0;
      w_mem_a[k]   = (k < 4) ? 32'h3F80_0000 : 32'h3F00_0000;
      we_data_a[k] = '0;
      we_addr_a[k] = '0;
    end
    x_mem_a[0] = 32'h3F80_0000; x_mem_a[1] = 32'h4000_0000;
    x_mem_a[2] = 32'h4040_0000; x_mem_a[3] = 32'h4080_0000;
    b_mem_a[0] = 32'h3F00_0000; b_mem_a[1] = 32'hBF80_0000;
    x_mem_b[0] = 32'h4000_0000; x_mem_b[1] = 32'd0;
    w_mem_b[0] = 32'h4040_0000; w_mem_b[1] = 32'd0;
    b_mem_b[0] = 32'h3F80_0000; b_mem_b[1] = 32'd0;

    // Reset state
    step(3);
    check("rst_busy",   32'(busy_a), 32'd0);
    check("rst_done",   32'(done_a), 32'd0);
    check("rst_valid",  32'(j_x_valid_a), 32'd0);
    check("rst_last",   32'(j_x_last_a), 32'd0);
    check("rst_o_we",   32'(o_we_a), 32'd0);
    check("rst_x_addr", 32'(x_addr_a), 32'd0);
    check("rst_w_addr", 32'(w_addr_a), 32'd0);
    check("rst_b_addr", 32'(b_addr_a), 32'd0);
    rst = 1'b0;
    step(2);

    // Full layer with start re-pulsed in STREAM and in WAIT
    start_a = 1'b1; step(1); start_a = 1'b0;
    check("busy_after_start", 32'(busy_a), 32'd1);
    step(1); start_a = 1'b1; step(1); start_a = 1'b0;
    step(6); start_a = 1'b1; step(1); start_a = 1'b0;
    wait_done_a(200);
    step(3);
    check("run1_we_count", 32'(we_cnt_a), 32'd2);
    check("run1_addr0",    we_addr_a[0], 32'd0);
    check("run1_data0",    we_data_a[0], 32'h4128_0000);
    check("run1_addr1",    we_addr_a[1], 32'd1);
    check("run1_data1",    we_data_a[1], 32'h4080_0000);
    check("run1_done_count", 32'(done_cnt_a), 32'd1);
    check("run1_done_after_we", 32'(done_cyc_a - we_cyc_a), 32'd1);
    check("run1_runs_of_5",   32'(runs_ok_a), 32'd2);
    check("run1_runs_other",  32'(runs_bad_a), 32'd0);
    check("run1_last_ok",     32'(last_ok_a), 32'd2);
    check("run1_last_bad",    32'(last_bad_a), 32'd0);
    check("run1_sig_bad",     32'(sig_bad_a), 32'd0);
    check("run1_busy_idle",   32'(busy_a), 32'd0);

    // Spurious result in IDLE
    spur_valid = 1'b1; step(1); spur_valid = 1'b0;
    step(3);
    check("idle_spur_o_data", o_data_a, 32'h4080_0000);
    check("idle_spur_we",     32'(we_cnt_a), 32'd2);

    // Reset during WAIT of neuron 0; the in-flight result must be dropped
    start_a = 1'b1; step(1); start_a = 1'b0;
    step(7);
    rst = 1'b1; step(1);
    check("midrst_busy",  32'(busy_a), 32'd0);
    check("midrst_valid", 32'(j_x_valid_a), 32'd0);
    rst = 1'b0;
    step(25);
    check("midrst_no_we",   32'(we_cnt_a), 32'd2);
    check("midrst_no_done", 32'(done_cnt_a), 32'd1);
    check("midrst_busy_after", 32'(busy_a), 32'd0);
    check("midrst_stream_len", 32'(runs_ok_a), 32'd3);

    // Full layer again, spurious result during STREAM
    start_a = 1'b1; step(1); start_a = 1'b0;
    spur_valid = 1'b1; step(1); spur_valid = 1'b0;
    check("stream_spur_o_data", o_data_a, 32'h4080_0000);
    wait_done_a(200);
    step(3);
    check("run3_we_count", 32'(we_cnt_a), 32'd4);
    check("run3_addr0",    we_addr_a[2], 32'd0);
    check("run3_data0",    we_data_a[2], 32'h4128_0000);
    check("run3_addr1",    we_addr_a[3], 32'd1);
    check("run3_data1",    we_data_a[3], 32'h4080_0000);
    check("run3_done_count", 32'(done_cnt_a), 32'd2);
    check("run3_runs_of_5",  32'(runs_ok_a), 32'd5);
    check("run3_runs_other", 32'(runs_bad_a), 32'd0);
    check("run3_last_ok",    32'(last_ok_a), 32'd5);
    check("run3_last_bad",   32'(last_bad_a), 32'd0);
    check("run3_sig_bad",    32'(sig_bad_a), 32'd0);

    // Minimal layer: one input, one neuron
    start_b = 1'b1; step(1); start_b = 1'b0;
    for (int k = 0; k < 100 && done_cnt_b == 0; k++) step(1);
    step(3);
    check("b_we_count",   32'(we_cnt_b), 32'd1);
    check("b_data",       we_data_b, 32'h40E0_0000);
    check("b_addr",       we_addr_b, 32'd0);
    check("b_done_count", 32'(done_cnt_b), 32'd1);
    check("b_done_after_we", 32'(done_cyc_b - we_cyc_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
